cache_line_server: RTL and testbench

Memory-side responder for the cache controller's line-transfer protocol (`ddr_rd`/`ddr_wr`/`hiaddr` in, `cache_write_data`/`cache_read_data` strobes out). It services one 64-byte line at a time: a dirty write-back, a line fill, or a write-back followed by a fill. Each line moves as 32 16-bit words. The memory side is a burst port toward the SDRAM/DDR PHY. The block sits in the `ddr_clk` domain between `cache_controller` and the memory controller.

---
 rtl/cache_pkg.sv | 18 +
 rtl/line_fifo.sv | 53 +++++
 rtl/cache_line_server.sv | 190 +++++++++++++++++++
 tb/tb_cache_line_server.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared constants and state encoding for the cache line server.
package cache_pkg;

    localparam int unsigned ADDR_W     = 25;
    localparam int unsigned LINE_W     = 6;
    localparam int unsigned LINE_WORDS = 32;
    localparam int unsigned WORD_W     = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_REQ  = 3'd1,
        WB_DATA = 3'd2,
        FL_REQ  = 3'd3,
        FL_DATA = 3'd4,
        GAP     = 3'd5
    } state_t;

endpackage

// File: rtl/line_fifo.sv
// Synchronous show-ahead FIFO with async reset; head word is visible on dout.
module line_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage, pointers and occupancy; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[PTR_W'(i)] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/cache_line_server.sv
// Memory-side responder moving one cache line per request: write-back, fill, or both.
module cache_line_server
    import cache_pkg::*;
#(
    parameter int unsigned ADDR       = ADDR_W,
    parameter int unsigned LINE       = LINE_W,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                   ddr_clk,
    input  logic                   rst,
    input  logic                   ddr_rd,
    input  logic                   ddr_wr,
    input  logic [ADDR-LINE-1:0]   hiaddr,
    output logic [WORD_W-1:0]      cache_din,
    input  logic [WORD_W-1:0]      cache_dout,
    output logic                   cache_write_data,
    output logic                   cache_read_data,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [ADDR-2:0]        mem_addr,
    input  logic                   mem_ack,
    output logic [WORD_W-1:0]      mem_wdata,
    output logic                   mem_wvalid,
    input  logic                   mem_wready,
    input  logic [WORD_W-1:0]      mem_rdata,
    input  logic                   mem_rvalid,
    output logic                   busy
);

    localparam int unsigned HI_W  = ADDR - LINE;
    localparam int unsigned WORDS = 2 ** (LINE - 1);
    localparam int unsigned CNT_W = LINE;
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

    state_t              state;
    state_t              next_state;
    logic [HI_W-1:0]     hi_lat;
    logic [CNT_W-1:0]    strobe_cnt;
    logic [CNT_W-1:0]    xfer_cnt;
    logic                gap_cnt;
    logic [RD_LAT-1:0]   dly;
    logic [SUM_W-1:0]    in_flight;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [OCC_W-1:0]    fifo_count;
    logic [WORD_W-1:0]   fifo_head;

    logic                mem_req_c;
    logic                mem_we_c;
    logic                busy_c;
    logic                rd_c;
    logic                cwd_c;
    logic [WORD_W-1:0]   din_c;

    // Write-back buffer: a word enters RD_LAT cycles after its strobe.
    assign fifo_push  = dly[RD_LAT-1];
    assign fifo_pop   = mem_wvalid && mem_wready;
    assign mem_wvalid = !fifo_empty;
    assign mem_wdata  = fifo_empty ? '0 : fifo_head;
    assign mem_addr   = {hi_lat, {(LINE-1){1'b0}}};

    line_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wb_fifo (
        .clk   (ddr_clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (cache_dout),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Strobes issued whose word has not yet landed in the FIFO.
    always_comb begin
        in_flight = SUM_W'(cache_read_data);
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight + SUM_W'(dly[i]);
        end
    end

    // State register.
    always_ff @(posedge ddr_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a write-back takes priority over a fill.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (ddr_wr) begin
                    next_state = WB_REQ;
                end else if (ddr_rd) begin
                    next_state = FL_REQ;
                end
            end
            WB_REQ:  if (mem_ack) next_state = WB_DATA;
            WB_DATA: if (fifo_pop && xfer_cnt == CNT_W'(WORDS - 1)) next_state = GAP;
            FL_REQ:  if (mem_ack) next_state = FL_DATA;
            FL_DATA: if (mem_rvalid && xfer_cnt == CNT_W'(WORDS - 1)) next_state = GAP;
            GAP:     if (gap_cnt) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode; strobes are throttled so the FIFO can never overflow.
    always_comb begin
        mem_req_c = (next_state == WB_REQ) || (next_state == FL_REQ);
        mem_we_c  = (next_state == WB_REQ) || (next_state == WB_DATA);
        busy_c    = (next_state != IDLE);
        rd_c      = 1'b0;
        cwd_c     = 1'b0;
        din_c     = cache_din;
        if (state == WB_DATA && strobe_cnt < CNT_W'(WORDS) && !fifo_full &&
            (SUM_W'(fifo_count) + in_flight) < SUM_W'(FIFO_DEPTH)) begin
            rd_c = 1'b1;
        end
        if (state == FL_DATA && mem_rvalid) begin
            cwd_c = 1'b1;
            din_c = mem_rdata;
        end
    end

    // Registered outputs.
    always_ff @(posedge ddr_clk or posedge rst) begin
        if (rst) begin
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            busy             <= 1'b0;
            cache_read_data  <= 1'b0;
            cache_write_data <= 1'b0;
            cache_din        <= '0;
        end else begin
            mem_req          <= mem_req_c;
            mem_we           <= mem_we_c;
            busy             <= busy_c;
            cache_read_data  <= rd_c;
            cache_write_data <= cwd_c;
            cache_din        <= din_c;
        end
    end

    // Per-burst counters, read-latency pipe, gap timer and line address latch.
    always_ff @(posedge ddr_clk or posedge rst) begin
        if (rst) begin
            strobe_cnt <= '0;
            xfer_cnt   <= '0;
            gap_cnt    <= 1'b0;
            dly        <= '0;
            hi_lat     <= '0;
        end else begin
            dly     <= (dly << 1) | RD_LAT'(cache_read_data);
            gap_cnt <= (state == GAP) && !gap_cnt;
            if (state == IDLE && (ddr_wr || ddr_rd)) begin
                hi_lat <= hiaddr;
            end
            unique case (state)
                WB_DATA: begin
                    strobe_cnt <= strobe_cnt + CNT_W'(rd_c);
                    xfer_cnt   <= xfer_cnt + CNT_W'(fifo_pop);
                end
                FL_DATA: begin
                    xfer_cnt <= xfer_cnt + CNT_W'(mem_rvalid);
                end
                GAP: begin
                    strobe_cnt <= strobe_cnt;
                    xfer_cnt   <= xfer_cnt;
                end
                default: begin
                    strobe_cnt <= '0;
                    xfer_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_server.sv
// Self-checking bench for cache_line_server: cache/memory models plus a line-level scoreboard.
module tb_cache_line_server;
    import cache_pkg::*;

    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int          WORDS      = LINE_WORDS;

    logic        ddr_clk;
    logic        rst;
    logic        ddr_rd;
    logic        ddr_wr;
    logic [18:0] hiaddr;
    logic [15:0] cache_din;
    logic [15:0] cache_dout;
    logic        cache_write_data;
    logic        cache_read_data;
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_wdata;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic        busy;

    int tests = 0;
    int fails = 0;

    // Scoreboard state.
    bit          fill_open = 0;
    bit          exp_pulse = 0;
    logic [15:0] exp_din = '0;
    int          fill_n = 0;
    int          fill_seen = 0;
    logic [15:0] fill_first = '0;
    logic [15:0] fill_last = '0;
    bit          wb_open = 0;
    bit          wb_done = 0;
    bit          wv_seen = 0;
    int          strobes = 0;
    int          pops = 0;
    int          cyc = 0;
    int          first_strobe_cyc = 0;
    logic [15:0] wb_base = 16'h0000;

    cache_line_server #(
        .ADDR       (ADDR_W),
        .LINE       (LINE_W),
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .ddr_clk          (ddr_clk),
        .rst              (rst),
        .ddr_rd           (ddr_rd),
        .ddr_wr           (ddr_wr),
        .hiaddr           (hiaddr),
        .cache_din        (cache_din),
        .cache_dout       (cache_dout),
        .cache_write_data (cache_write_data),
        .cache_read_data  (cache_read_data),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_ack          (mem_ack),
        .mem_wdata        (mem_wdata),
        .mem_wvalid       (mem_wvalid),
        .mem_wready       (mem_wready),
        .mem_rdata        (mem_rdata),
        .mem_rvalid       (mem_rvalid),
        .busy             (busy)
    );

    initial begin
        ddr_clk = 1'b0;
        forever #5 ddr_clk = ~ddr_clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ddr_clk);
        #1;
    endtask

    // Cache model: the k-th read strobe of a write-back yields word wb_base+k, RD_LAT cycles later.
    initial begin
        logic [7:0] h;
        int         k;
        h = '0;
        k = 0;
        cache_dout = 16'hBAD0;
        forever begin
            @(posedge ddr_clk);
            #1;
            if (rst) begin
                h = '0;
                k = 0;
                cache_dout = 16'hBAD0;
            end else begin
                if (mem_req && mem_we) k = 0;
                h = {h[6:0], cache_read_data};
                if (h[RD_LAT]) begin
                    cache_dout = 16'(wb_base + 16'(k));
                    k++;
                end else begin
                    cache_dout = 16'hBAD0 ^ 16'(k);
                end
            end
        end
    end

    // Line-level scoreboard, checked on every falling edge.
    initial begin
        forever begin
            @(negedge ddr_clk);
            cyc++;
            if (rst) begin
                fill_open = 0;
                exp_pulse = 0;
                wb_open   = 0;
            end else begin
                chk("cache_write_data", 32'(cache_write_data), 32'(exp_pulse));
                if (cache_write_data && exp_pulse) begin
                    chk("cache_din", 32'(cache_din), 32'(exp_din));
                    if (fill_seen == 0) fill_first = cache_din;
                    fill_last = cache_din;
                    fill_seen++;
                end
                exp_pulse = 0;
                if (fill_open && mem_rvalid) begin
                    exp_pulse = 1;
                    exp_din   = mem_rdata;
                    fill_n++;
                    if (fill_n == WORDS) fill_open = 0;
                end
                if (mem_req && mem_ack && !mem_we) begin
                    fill_open = 1;
                    fill_n    = 0;
                    fill_seen = 0;
                end
                if (wb_open) begin
                    if (cache_read_data) begin
                        strobes++;
                        if (strobes == 1) first_strobe_cyc = cyc;
                    end
                    chk("wb_occupancy", 32'((strobes - pops) <= int'(FIFO_DEPTH)), 32'd1);
                    if (mem_wvalid && !wv_seen) begin
                        wv_seen = 1;
                        chk("wvalid_latency", 32'((cyc - first_strobe_cyc) >= int'(RD_LAT) + 1), 32'd1);
                    end
                    if (mem_wvalid && mem_wready) begin
                        chk("mem_wdata", 32'(mem_wdata), 32'(16'(wb_base + 16'(pops))));
                        pops++;
                        if (pops == WORDS) begin
                            chk("wb_strobes", 32'(strobes), 32'(WORDS));
                            wb_open = 0;
                            wb_done = 1;
                        end
                    end
                end else begin
                    chk("idle_read_strobe", 32'(cache_read_data), 32'd0);
                    chk("idle_wvalid", 32'(mem_wvalid), 32'd0);
                end
                if (mem_req && mem_ack && mem_we) begin
                    wb_open = 1;
                    strobes = 0;
                    pops    = 0;
                    wv_seen = 0;
                    wb_done = 0;
                end
            end
        end
    end

    // Memory side of a fill: accept the burst, return 32 words every 'period' cycles, then a stray 33rd.
    task automatic serve_fill(input logic [23:0] exp_addr, input logic [15:0] base,
                              input int period, input bit from_idle);
        int n;
        n = 0;
        while (!mem_req && n < 100) begin
            tick();
            n++;
        end
        if (from_idle) chk("fill_req_latency", 32'(n), 32'd1);
        chk("fill_req_seen", 32'(mem_req), 32'd1);
        chk("fill_addr", 32'(mem_addr), 32'(exp_addr));
        chk("fill_we", 32'(mem_we), 32'd0);
        ddr_rd  = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("fill_req_drop", 32'(mem_req), 32'd0);
        for (int i = 0; i < WORDS; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'(base + 16'(i));
            tick();
            mem_rvalid = 1'b0;
            for (int j = 1; j < period; j++) tick();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 16'hFFFF;
        tick();
        mem_rvalid = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk("fill_back_to_idle", 32'(busy), 32'd0);
        chk("fill_word_count", 32'(fill_seen), 32'(WORDS));
    endtask

    // Write-back of one line, optionally followed by a fill at a newly presented address.
    task automatic do_wb(input logic [18:0] hi_wb, input logic [23:0] exp_wb, input bit with_fill,
                         input logic [18:0] hi_fill, input logic [23:0] exp_fill, input bit slow_ready,
                         input logic [15:0] base_wb, input logic [15:0] base_fill);
        int n;
        wb_base = base_wb;
        ddr_wr  = 1'b1;
        ddr_rd  = with_fill;
        hiaddr  = hi_wb;
        n = 0;
        while (!mem_req && n < 100) begin
            tick();
            n++;
        end
        chk("wb_req_latency", 32'(n), 32'd1);
        chk("wb_addr", 32'(mem_addr), 32'(exp_wb));
        chk("wb_we", 32'(mem_we), 32'd1);
        ddr_wr  = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("wb_req_drop", 32'(mem_req), 32'd0);
        n = 0;
        while (!wb_done && n < 3000) begin
            mem_wready = slow_ready ? (n % 4 == 0) : 1'b1;
            tick();
            n++;
        end
        chk("wb_complete", 32'(wb_done), 32'd1);
        mem_wready = 1'b0;
        if (with_fill) begin
            hiaddr = hi_fill;
            serve_fill(exp_fill, base_fill, 1, 0);
        end else begin
            n = 0;
            while (busy && n < 20) begin
                tick();
                n++;
            end
            chk("wb_back_to_idle", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst        = 1'b1;
        ddr_rd     = 1'b0;
        ddr_wr     = 1'b0;
        hiaddr     = '0;
        mem_ack    = 1'b0;
        mem_wready = 1'b0;
        mem_rdata  = '0;
        mem_rvalid = 1'b0;
        repeat (3) tick();

        // Reset state.
        chk("rst_strobes", 32'({cache_write_data, cache_read_data, mem_req, mem_we, mem_wvalid, busy}), 32'd0);
        chk("rst_cache_din", 32'(cache_din), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;
        tick();

        // Plain fill.
        ddr_rd = 1'b1;
        hiaddr = 19'h01234;
        serve_fill(24'h024680, 16'h0000, 1, 1);
        chk("fill1_first_word", 32'(fill_first), 32'h0000);
        chk("fill1_last_word", 32'(fill_last), 32'h001F);
        tick();

        // Write-back followed by fill at a new address.
        do_wb(19'h00ABC, 24'h015780, 1'b1, 19'h00DEF, 24'h01BDE0, 1'b0, 16'hA500, 16'h5000);
        chk("wbfill_first_word", 32'(fill_first), 32'h5000);
        tick();

        // Write-back under 25% write-ready back-pressure.
        do_wb(19'h00100, 24'h002000, 1'b0, 19'h0, 24'h0, 1'b1, 16'hC300, 16'h0);
        tick();

        // Slow fill: one memory word every third cycle.
        ddr_rd = 1'b1;
        hiaddr = 19'h00002;
        serve_fill(24'h000040, 16'h8000, 3, 1);
        chk("slow_last_word", 32'(fill_last), 32'h801F);
        tick();

        // Reset during word 10 of a fill, then a fresh fill.
        ddr_rd = 1'b1;
        hiaddr = 19'h00055;
        n = 0;
        while (!mem_req && n < 100) begin
            tick();
            n++;
        end
        chk("abort_req_seen", 32'(mem_req), 32'd1);
        ddr_rd  = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'(16'h2000 + 16'(i));
            tick();
        end
        mem_rdata = 16'h200A;
        chk("abort_busy_before", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_strobes", 32'({cache_write_data, cache_read_data, mem_req, mem_we, mem_wvalid, busy}), 32'd0);
        chk("arst_cache_din", 32'(cache_din), 32'd0);
        chk("arst_mem_addr", 32'(mem_addr), 32'd0);
        @(posedge ddr_clk);
        #1;
        mem_rvalid = 1'b0;
        rst        = 1'b0;
        tick();
        ddr_rd = 1'b1;
        hiaddr = 19'h00055;
        serve_fill(24'h000AA0, 16'h3000, 1, 1);
        chk("fresh_first_word", 32'(fill_first), 32'h3000);
        tick();

        // Stray read-valid while idle.
        for (int i = 0; i < 3; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 16'h7777;
            tick();
            chk("stray_busy", 32'(busy), 32'd0);
            chk("stray_req", 32'(mem_req), 32'd0);
        end
        mem_rvalid = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
